// File: rtl/snitch_icache_lookup_sched.sv
// ---------------------------------------------------------------------------
// snitch_icache_lookup_sched
//
// Front-end scheduler for the L1 instruction-cache lookup stage.
//  - Shares the single lookup request port among NR_PORTS fetch requesters
//    with zero-latency round-robin arbitration. The source port index is
//    prepended to the forwarded request ID.
//  - Sequences cache flushes. It stops granting, drains the outstanding
//    lookups, handshakes the lookup flush port, and then acknowledges every
//    flush requester.
//
// Optional feature macro: SNITCH_ICACHE_SCHED_PRIO_EN
//  - defined     : port 0 has fixed highest priority. Ports 1..NR_PORTS-1
//                  round-robin among themselves.
//  - not defined : pure round-robin over all ports.
//
// Ports
//  clk_i, rst_i        clock, synchronous active-high reset
//  port_addr_i/id_i    per-port fetch address / request ID
//  port_valid_i        per-port request valid
//  port_ready_o        per-port request accepted (only the granted port)
//  flush_req_i         per-port flush request (level, held until ack)
//  flush_ack_o         per-port one-cycle flush-done pulse
//  lk_addr_o/id_o      lookup request address / {port index, port ID}
//  lk_valid_o          lookup request valid
//  lk_ready_i          lookup request ready
//  rsp_valid_i/ready_i lookup response handshake (observed only)
//  lk_flush_valid_o    flush request to the lookup stage
//  lk_flush_ready_i    lookup stage flush ready
//  busy_o              flush in progress or lookups outstanding
// ---------------------------------------------------------------------------
module snitch_icache_lookup_sched #(
    parameter int unsigned NR_PORTS        = 4,
    parameter int unsigned FETCH_AW        = 32,
    parameter int unsigned ID_WIDTH        = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [NR_PORTS-1:0][FETCH_AW-1:0]          port_addr_i,
    input  logic [NR_PORTS-1:0][ID_WIDTH-1:0]          port_id_i,
    input  logic [NR_PORTS-1:0]                        port_valid_i,
    output logic [NR_PORTS-1:0]                        port_ready_o,
    input  logic [NR_PORTS-1:0]                        flush_req_i,
    output logic [NR_PORTS-1:0]                        flush_ack_o,
    output logic [FETCH_AW-1:0]                        lk_addr_o,
    output logic [ID_WIDTH+$clog2(NR_PORTS)-1:0]       lk_id_o,
    output logic                                       lk_valid_o,
    input  logic                                       lk_ready_i,
    input  logic                                       rsp_valid_i,
    input  logic                                       rsp_ready_i,
    output logic                                       lk_flush_valid_o,
    input  logic                                       lk_flush_ready_i,
    output logic                                       busy_o
);

    localparam int unsigned IDX_W = $clog2(NR_PORTS);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NR_PORTS - 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_FLUSH = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t                 state_reg;
    logic [IDX_W-1:0]       rr_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   lock_reg;
    logic [IDX_W-1:0]       lock_idx_reg;
    logic [FETCH_AW-1:0]    lock_addr_reg;
    logic [ID_WIDTH-1:0]    lock_id_reg;

    state_t                 state_next;
    logic [IDX_W-1:0]       rr_next;
    logic [CNT_W-1:0]       cnt_next;

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    logic                   arb_valid;
    logic [IDX_W-1:0]       arb_idx;
    logic                   grant_allowed;
    logic [IDX_W-1:0]       sel_idx;
    logic                   lk_hs;
    logic                   rsp_hs;
    logic                   cnt_inc;
    logic                   cnt_dec;

    // Wraps an offset from the pointer into a legal port index.
    function automatic logic [IDX_W-1:0] wrap_all(input int unsigned v);
        return IDX_W'(v % NR_PORTS);
    endfunction

    // Wraps an offset into the range 1..NR_PORTS-1 (port 0 excluded).
    function automatic logic [IDX_W-1:0] wrap_low(input int unsigned v);
        return IDX_W'(1 + (v % (NR_PORTS - 1)));
    endfunction

    always_comb begin
        arb_valid = 1'b0;
        arb_idx   = '0;
`ifdef SNITCH_ICACHE_SCHED_PRIO_EN
        if (port_valid_i[0]) begin
            arb_valid = 1'b1;
            arb_idx   = '0;
        end else begin
            // A pointer of 0 (reset value) behaves like a pointer of 1,
            // since port 0 never takes part in the rotation.
            for (int i = 0; i < int'(NR_PORTS) - 1; i++) begin
                if (!arb_valid &&
                    port_valid_i[wrap_low(((rr_reg == '0) ? 0 : int'(rr_reg) - 1) + i)]) begin
                    arb_valid = 1'b1;
                    arb_idx   = wrap_low(((rr_reg == '0) ? 0 : int'(rr_reg) - 1) + i);
                end
            end
        end
`else
        for (int i = 0; i < int'(NR_PORTS); i++) begin
            if (!arb_valid && port_valid_i[wrap_all(int'(rr_reg) + i)]) begin
                arb_valid = 1'b1;
                arb_idx   = wrap_all(int'(rr_reg) + i);
            end
        end
`endif
    end

    // New grants only in RUN, with room for another lookup and no flush
    // pending. A locked request ignores all of this and completes.
    assign grant_allowed = !rst_i && (state_reg == S_RUN) && !(|flush_req_i)
                           && (cnt_reg != CNT_MAX);

    assign sel_idx    = lock_reg ? lock_idx_reg : arb_idx;
    assign lk_valid_o = !rst_i && (lock_reg || (grant_allowed && arb_valid));

    always_comb begin
        lk_addr_o = '0;
        lk_id_o   = '0;
        if (lk_valid_o) begin
            if (lock_reg) begin
                lk_addr_o = lock_addr_reg;
                lk_id_o   = {lock_idx_reg, lock_id_reg};
            end else begin
                lk_addr_o = port_addr_i[arb_idx];
                lk_id_o   = {arb_idx, port_id_i[arb_idx]};
            end
        end
    end

    assign lk_hs  = lk_valid_o && lk_ready_i;
    assign rsp_hs = rsp_valid_i && rsp_ready_i;

    generate
        for (genvar gi = 0; gi < NR_PORTS; gi++) begin : g_port
            assign port_ready_o[gi] = lk_hs && (sel_idx == IDX_W'(gi));
            assign flush_ack_o[gi]  = !rst_i && (state_reg == S_ACK) && flush_req_i[gi];
        end
    endgenerate

    assign lk_flush_valid_o = !rst_i && (state_reg == S_FLUSH);
    assign busy_o           = !rst_i && ((state_reg != S_RUN) || (cnt_reg != '0));

    // -----------------------------------------------------------------------
    // Outstanding counter: saturating both ways, so a stray response at zero
    // is dropped instead of wrapping.
    // -----------------------------------------------------------------------
    assign cnt_inc = lk_hs && (cnt_reg != CNT_MAX);
    assign cnt_dec = rsp_hs && (cnt_reg != '0);

    always_comb begin
        cnt_next = cnt_reg;
        if (cnt_inc && !cnt_dec) begin
            cnt_next = cnt_reg + 1'b1;
        end else if (!cnt_inc && cnt_dec) begin
            cnt_next = cnt_reg - 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Round-robin pointer update
    // -----------------------------------------------------------------------
    always_comb begin
        rr_next = rr_reg;
        if (lk_hs) begin
`ifdef SNITCH_ICACHE_SCHED_PRIO_EN
            if (sel_idx != '0) begin
                rr_next = (sel_idx == IDX_LAST) ? IDX_W'(1) : sel_idx + 1'b1;
            end
`else
            rr_next = (sel_idx == IDX_LAST) ? '0 : sel_idx + 1'b1;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Flush sequencing
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_RUN:   if (|flush_req_i) state_next = S_DRAIN;
            // Drained once nothing is being presented and the counter,
            // including a response retiring this cycle, reaches zero.
            S_DRAIN: if (!lk_valid_o && (cnt_next == '0)) state_next = S_FLUSH;
            S_FLUSH: if (lk_flush_ready_i) state_next = S_ACK;
            S_ACK:   state_next = S_RUN;
            default: state_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= S_RUN;
            rr_reg        <= '0;
            cnt_reg       <= '0;
            lock_reg      <= 1'b0;
            lock_idx_reg  <= '0;
            lock_addr_reg <= '0;
            lock_id_reg   <= '0;
        end else begin
            state_reg <= state_next;
            rr_reg    <= rr_next;
            cnt_reg   <= cnt_next;
            // Freeze the presented request until the lookup stage accepts it,
            // so a newly valid port or a state change cannot alter it.
            if (lk_valid_o && !lk_ready_i) begin
                lock_reg      <= 1'b1;
                lock_idx_reg  <= sel_idx;
                lock_addr_reg <= lk_addr_o;
                lock_id_reg   <= lk_id_o[ID_WIDTH-1:0];
            end else if (lk_hs) begin
                lock_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_snitch_icache_lookup_sched.sv
// ---------------------------------------------------------------------------
// Testbench for snitch_icache_lookup_sched (NR_PORTS=4, FETCH_AW=32,
// ID_WIDTH=4, MAX_OUTSTANDING=4). Cycle-by-cycle directed vectors with
// hand-computed expected outputs; inputs are driven 1 ns after the rising
// edge and outputs compared 3 ns later.
// ---------------------------------------------------------------------------
module tb_snitch_icache_lookup_sched;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [3:0][31:0]  port_addr_i;
    logic [3:0][3:0]   port_id_i;
    logic [3:0]        port_valid_i;
    logic [3:0]        port_ready_o;
    logic [3:0]        flush_req_i;
    logic [3:0]        flush_ack_o;
    logic [31:0]       lk_addr_o;
    logic [5:0]        lk_id_o;
    logic              lk_valid_o;
    logic              lk_ready_i;
    logic              rsp_valid_i;
    logic              rsp_ready_i;
    logic              lk_flush_valid_o;
    logic              lk_flush_ready_i;
    logic              busy_o;

    always #5 clk_i = ~clk_i;

    snitch_icache_lookup_sched #(
        .NR_PORTS        (4),
        .FETCH_AW        (32),
        .ID_WIDTH        (4),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .port_addr_i      (port_addr_i),
        .port_id_i        (port_id_i),
        .port_valid_i     (port_valid_i),
        .port_ready_o     (port_ready_o),
        .flush_req_i      (flush_req_i),
        .flush_ack_o      (flush_ack_o),
        .lk_addr_o        (lk_addr_o),
        .lk_id_o          (lk_id_o),
        .lk_valid_o       (lk_valid_o),
        .lk_ready_i       (lk_ready_i),
        .rsp_valid_i      (rsp_valid_i),
        .rsp_ready_i      (rsp_ready_i),
        .lk_flush_valid_o (lk_flush_valid_o),
        .lk_flush_ready_i (lk_flush_ready_i),
        .busy_o           (busy_o)
    );

    typedef struct {
        logic       ck;     // compare outputs this cycle
        logic       rst;
        logic [3:0] valid;
        logic       lkr;
        logic       rsp;
        logic [3:0] freq;
        logic       frdy;
        logic       ev;     // expected lk_valid_o
        logic [5:0] eid;    // expected lk_id_o (only when ev)
        logic [3:0] epr;    // expected port_ready_o
        logic       eb;     // expected busy_o
        logic       efv;    // expected lk_flush_valid_o
        logic [3:0] eack;   // expected flush_ack_o
    } vec_t;

    int passed = 0;
    int total  = 0;
    int vnum   = 0;

    function automatic logic [31:0] addr_of(input int p);
        return 32'hA000_0004 + 32'(p) * 32'h100;
    endfunction

    function automatic logic [3:0] id_of(input int p);
        return 4'(p + 3);
    endfunction

    // {port index, port ID} expected on lk_id_o for port p
    function automatic logic [5:0] tag(input int p);
        return {2'(p), id_of(p)};
    endfunction

    function automatic vec_t mk(input logic ck, input logic rst, input logic [3:0] valid,
                                input logic lkr, input logic rsp, input logic [3:0] freq,
                                input logic frdy, input logic ev, input logic [5:0] eid,
                                input logic [3:0] epr, input logic eb, input logic efv,
                                input logic [3:0] eack);
        vec_t v;
        v.ck = ck; v.rst = rst; v.valid = valid; v.lkr = lkr; v.rsp = rsp;
        v.freq = freq; v.frdy = frdy; v.ev = ev; v.eid = eid; v.epr = epr;
        v.eb = eb; v.efv = efv; v.eack = eack;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL vec %0d %s: got %h expected %h", vnum, nm, act, exp);
    endtask

    task automatic apply(input vec_t v);
        rst_i            = v.rst;
        port_valid_i     = v.valid;
        lk_ready_i       = v.lkr;
        rsp_valid_i      = v.rsp;
        rsp_ready_i      = v.rsp;
        flush_req_i      = v.freq;
        lk_flush_ready_i = v.frdy;
        #3;
        $display("vec %0d: valid=%b lkr=%b rsp=%b freq=%b frdy=%b rst=%b -> lkv=%b id=%h pr=%b busy=%b fv=%b ack=%b",
                 vnum, v.valid, v.lkr, v.rsp, v.freq, v.frdy, v.rst,
                 lk_valid_o, lk_id_o, port_ready_o, busy_o, lk_flush_valid_o, flush_ack_o);
        if (v.ck) begin
            chk("lk_valid", 32'(lk_valid_o), 32'(v.ev));
            if (v.ev) begin
                chk("lk_id", 32'(lk_id_o), 32'(v.eid));
                chk("lk_addr", lk_addr_o, addr_of(int'(v.eid[5:4])));
            end
            chk("port_ready", 32'(port_ready_o), 32'(v.epr));
            chk("busy", 32'(busy_o), 32'(v.eb));
            chk("flush_valid", 32'(lk_flush_valid_o), 32'(v.efv));
            chk("flush_ack", 32'(flush_ack_o), 32'(v.eack));
        end
        vnum++;
        @(posedge clk_i);
        #1;
    endtask

    // Shorthand: checked, reset low
    task automatic v(input logic [3:0] valid, input logic lkr, input logic rsp,
                     input logic [3:0] freq, input logic frdy, input logic ev,
                     input logic [5:0] eid, input logic [3:0] epr, input logic eb,
                     input logic efv, input logic [3:0] eack);
        apply(mk(1'b1, 1'b0, valid, lkr, rsp, freq, frdy, ev, eid, epr, eb, efv, eack));
    endtask

    task automatic do_reset();
        apply(mk(1'b0, 1'b1, 4'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 6'h0, 4'b0, 1'b0, 1'b0, 4'b0));
        apply(mk(1'b0, 1'b1, 4'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 6'h0, 4'b0, 1'b0, 1'b0, 4'b0));
    endtask

    vec_t tbl [9];

    initial begin
        for (int p = 0; p < 4; p++) begin
            port_addr_i[p] = addr_of(p);
            port_id_i[p]   = id_of(p);
        end
        rst_i = 1'b1; port_valid_i = '0; lk_ready_i = 1'b0; rsp_valid_i = 1'b0;
        rsp_ready_i = 1'b0; flush_req_i = '0; lk_flush_ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        do_reset();

        // Reset state, then all ports valid with lk_ready high: grants
        // 0,1,2,3, stop at 4 outstanding, one response frees one slot.
        //              ck   rst   valid    lkr   rsp   freq  frdy  ev    eid     epr      eb    efv   eack
        tbl[0] = mk(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 6'h0,   4'b0000, 1'b0, 1'b0, 4'b0);
        tbl[1] = mk(1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 4'b0, 1'b0, 1'b1, tag(0), 4'b0001, 1'b0, 1'b0, 4'b0);
        tbl[2] = mk(1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 4'b0, 1'b0, 1'b1, tag(1), 4'b0010, 1'b1, 1'b0, 4'b0);
        tbl[3] = mk(1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 4'b0, 1'b0, 1'b1, tag(2), 4'b0100, 1'b1, 1'b0, 4'b0);
        tbl[4] = mk(1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 4'b0, 1'b0, 1'b1, tag(3), 4'b1000, 1'b1, 1'b0, 4'b0);
        tbl[5] = mk(1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 6'h0,   4'b0000, 1'b1, 1'b0, 4'b0);
        tbl[6] = mk(1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 4'b0, 1'b0, 1'b0, 6'h0,   4'b0000, 1'b1, 1'b0, 4'b0);
        tbl[7] = mk(1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 4'b0, 1'b0, 1'b1, tag(0), 4'b0001, 1'b1, 1'b0, 4'b0);
        tbl[8] = mk(1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 6'h0,   4'b0000, 1'b1, 1'b0, 4'b0);
        for (int i = 0; i < 9; i++) apply(tbl[i]);

        do_reset();
        // Grant lock: port 2 stalls 3 cycles while port 1 becomes valid.
        //   valid    lkr   rsp   freq     frdy  ev    eid     epr      eb    efv   eack
        v(4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, tag(2), 4'b0000, 1'b0, 1'b0, 4'b0000);
        v(4'b0110, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, tag(2), 4'b0000, 1'b0, 1'b0, 4'b0000);
        v(4'b0110, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, tag(2), 4'b0000, 1'b0, 1'b0, 4'b0000);
        v(4'b0110, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, tag(2), 4'b0100, 1'b0, 1'b0, 4'b0000);
        // pointer now 3: search 3,0,1 picks port 1
        v(4'b0110, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, tag(1), 4'b0010, 1'b1, 1'b0, 4'b0000);

        // Flush with 2 outstanding; responses 3 cycles apart.
        v(4'b0000, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 6'h0, 4'b0000, 1'b1, 1'b0, 4'b0000);
        v(4'b0000, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 6'h0, 4'b0000, 1'b1, 1'b0, 4'b0000);
        v(4'b0000, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 6'h0, 4'b0000, 1'b1, 1'b0, 4'b0000);
        v(4'b0000, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 6'h0, 4'b0000, 1'b1, 1'b0, 4'b0000);
        v(4'b0000, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 6'h0, 4'b0000, 1'b1, 1'b0, 4'b0000);
        // FLUSH; port 3 joins, ready two cycles later, ack covers both
        v(4'b0000, 1'b0, 1'b0, 4'b1010, 1'b0, 1'b0, 6'h0, 4'b0000, 1'b1, 1'b1, 4'b0000);
        v(4'b0000, 1'b0, 1'b0, 4'b1010, 1'b0, 1'b0, 6'h0, 4'b0000, 1'b1, 1'b1, 4'b0000);
        v(4'b0000, 1'b0, 1'b0, 4'b1010, 1'b1, 1'b0, 6'h0, 4'b0000, 1'b1, 1'b1, 4'b0000);
        v(4'b0000, 1'b0, 1'b0, 4'b1010, 1'b0, 1'b0, 6'h0, 4'b0000, 1'b1, 1'b0, 4'b1010);
        // back in RUN; port 1 still requesting starts a new flush
        v(4'b0000, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 6'h0, 4'b0000, 1'b0, 1'b0, 4'b0000);
        v(4'b0000, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 6'h0, 4'b0000, 1'b1, 1'b0, 4'b0000);
        v(4'b0000, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 6'h0, 4'b0000, 1'b1, 1'b1, 4'b0000);
        // reset while in FLUSH: next cycle idle RUN, no ack
        apply(mk(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 6'h0, 4'b0000, 1'b0, 1'b0, 4'b0));
        v(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 6'h0, 4'b0000, 1'b0, 1'b0, 4'b0000);
        // pointer was reset: port 0 first
        v(4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, tag(0), 4'b0001, 1'b0, 1'b0, 4'b0000);

        // Simultaneous lookup and response at outstanding=1 keeps 1;
        // one response empties it; a response at 0 is ignored.
        v(4'b0010, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, tag(1), 4'b0010, 1'b1, 1'b0, 4'b0000);
        v(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 6'h0, 4'b0000, 1'b1, 1'b0, 4'b0000);
        v(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 6'h0, 4'b0000, 1'b1, 1'b0, 4'b0000);
        v(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 6'h0, 4'b0000, 1'b0, 1'b0, 4'b0000);
        v(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 6'h0, 4'b0000, 1'b0, 1'b0, 4'b0000);

        // Ports 0 and 1 always valid (pointer at 2, outstanding held at 1).
`ifdef SNITCH_ICACHE_SCHED_PRIO_EN
        v(4'b0011, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, tag(0), 4'b0001, 1'b0, 1'b0, 4'b0000);
        v(4'b0011, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, tag(0), 4'b0001, 1'b1, 1'b0, 4'b0000);
        v(4'b0011, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, tag(0), 4'b0001, 1'b1, 1'b0, 4'b0000);
        v(4'b0011, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, tag(0), 4'b0001, 1'b1, 1'b0, 4'b0000);
`else
        v(4'b0011, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, tag(0), 4'b0001, 1'b0, 1'b0, 4'b0000);
        v(4'b0011, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, tag(1), 4'b0010, 1'b1, 1'b0, 4'b0000);
        v(4'b0011, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, tag(0), 4'b0001, 1'b1, 1'b0, 4'b0000);
        v(4'b0011, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, tag(1), 4'b0010, 1'b1, 1'b0, 4'b0000);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
